// File: rtl/mux_scan.sv
// Registered time-division scanning multiplexer.
// Steps a channel pointer through WAYS input words. Each channel is shown for
// DWELL cycles, and every SHOW is preceded by BLANK blanking cycles. The
// selected word, a binary select and a one-hot strobe are all driven from
// flops, so there is no combinational path from any input to any output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | scan stopped, all outputs at reset values, Sel = 0
// ST_BLANK | gap before a channel is shown; Valid, Y and strobe low
// ST_SHOW  | current channel driven on Y / SelOneHot, Valid high
//
// Hold and ForceEn are looked at only on the last SHOW cycle of a dwell.
// On that cycle Hold has priority over ForceEn, and ForceEn has priority
// over the normal increment. While Hold is asserted the dwell counter stays
// on its terminal value, so the decision is made again on every cycle.
module mux_scan #(
    parameter int  WIDTH = 3,
    parameter int  WAYS  = 9,
    parameter int  DWELL = 16,
    parameter int  BLANK = 2,
    localparam int SELW  = $clog2(WAYS)
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  En,
    input  logic                  Hold,
    input  logic                  ForceEn,
    input  logic [SELW-1:0]       ForceSel,
    input  logic [WAYS*WIDTH-1:0] D,
    output logic [WIDTH-1:0]      Y,
    output logic [SELW-1:0]       Sel,
    output logic [WAYS-1:0]       SelOneHot,
    output logic                  Valid,
    output logic                  Wrap
);

    // One counter width serves both the dwell and the blank counter.
    localparam int CNT_MAX_A = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_MAX   = (CNT_MAX_A > 2) ? CNT_MAX_A : 2;
    localparam int CNTW      = $clog2(CNT_MAX);

    localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL - 1);
    localparam logic [CNTW-1:0] BLANK_LAST = CNTW'((BLANK > 0) ? (BLANK - 1) : 0);
    localparam logic [SELW-1:0] SEL_LAST   = SELW'(WAYS - 1);
    // WAYS always fits in SELW+1 bits, even when WAYS is a power of two.
    localparam logic [SELW:0]   WAYS_W     = (SELW + 1)'(WAYS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [CNTW-1:0]   dwell_q, dwell_d;
    logic [CNTW-1:0]   blank_q, blank_d;
    logic              wrap_q, wrap_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [WAYS-1:0]   onehot_q, onehot_d;
    logic              valid_q, valid_d;

    logic              dwell_end;
    logic              force_ok;
    state_t            after_gap;

    assign dwell_end = (state_q == ST_SHOW) && (dwell_q == DWELL_LAST);
    // Out-of-range forced targets are ignored; the current channel is re-shown.
    assign force_ok  = ({1'b0, ForceSel} < WAYS_W);
    // With no blanking configured a new channel goes straight to SHOW.
    assign after_gap = (BLANK == 0) ? ST_SHOW : ST_BLANK;

    // State, pointer, counters and output registers; reset clears everything.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            dwell_q  <= '0;
            blank_q  <= '0;
            wrap_q   <= 1'b0;
            y_q      <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            dwell_q  <= dwell_d;
            blank_q  <= blank_d;
            wrap_q   <= wrap_d;
            y_q      <= y_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
        end
    end

    // Next state, channel pointer and counters; En low overrides everything.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        blank_d = blank_q;
        wrap_d  = 1'b0;

        if (!En) begin
            state_d = ST_IDLE;
            sel_d   = '0;
            dwell_d = '0;
            blank_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = after_gap;
                    sel_d   = '0;
                    dwell_d = '0;
                    blank_d = '0;
                end

                ST_BLANK: begin
                    if (blank_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        blank_d = '0;
                        dwell_d = '0;
                    end else begin
                        blank_d = blank_q + 1'b1;
                    end
                end

                ST_SHOW: begin
                    if (!dwell_end) begin
                        dwell_d = dwell_q + 1'b1;
                    end else if (Hold) begin
                        // Stay on this channel with the counter parked at its end.
                        dwell_d = dwell_q;
                    end else begin
                        if (ForceEn) begin
                            if (force_ok) begin
                                sel_d = ForceSel;
                            end
                        end else if (sel_q == SEL_LAST) begin
                            sel_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            sel_d = sel_q + 1'b1;
                        end
                        state_d = after_gap;
                        dwell_d = '0;
                        blank_d = '0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                    dwell_d = '0;
                    blank_d = '0;
                end
            endcase
        end
    end

    // Output values for the coming cycle: the word and strobe are live only in SHOW.
    always_comb begin
        valid_d  = (state_d == ST_SHOW);
        y_d      = '0;
        onehot_d = '0;
        if (valid_d) begin
            for (int k = 0; k < WAYS; k++) begin
                if (sel_d == SELW'(k)) begin
                    y_d         = D[k*WIDTH +: WIDTH];
                    onehot_d[k] = 1'b1;
                end
            end
        end
    end

    assign Y         = y_q;
    assign Sel       = sel_q;
    assign SelOneHot = onehot_q;
    assign Valid     = valid_q;
    assign Wrap      = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan (WIDTH=3, WAYS=9, DWELL=4, BLANK=1).
// The stimulus process pushes hand-computed SHOW words (edge, channel, value)
// and wrap edges into queues. A monitor on the falling edge pops one entry
// for every Valid cycle and one for every Wrap pulse.
module tb_mux_scan;

    localparam int WIDTH = 3;
    localparam int WAYS  = 9;
    localparam int DWELL = 4;
    localparam int BLANK = 1;
    localparam int SELW  = 4;
    localparam int SLOT  = DWELL + BLANK;

    logic                  Clk;
    logic                  Rst_n;
    logic                  En;
    logic                  Hold;
    logic                  ForceEn;
    logic [SELW-1:0]       ForceSel;
    logic [WAYS*WIDTH-1:0] D;
    logic [WIDTH-1:0]      Y;
    logic [SELW-1:0]       Sel;
    logic [WAYS-1:0]       SelOneHot;
    logic                  Valid;
    logic                  Wrap;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int base0  = 0;

    typedef struct {
        int cyc;
        int sel;
        int y;
    } exp_t;

    exp_t exp_q[$];
    int   wrap_q[$];

    mux_scan #(
        .WIDTH (WIDTH),
        .WAYS  (WAYS),
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .En        (En),
        .Hold      (Hold),
        .ForceEn   (ForceEn),
        .ForceSel  (ForceSel),
        .D         (D),
        .Y         (Y),
        .Sel       (Sel),
        .SelOneHot (SelOneHot),
        .Valid     (Valid),
        .Wrap      (Wrap)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #10000;
        $display("FAIL watchdog: run did not complete, edge=%0d", cyc - base0);
        $fatal(1, "watchdog expired");
    end

    // Monitor: compare every SHOW word and every Wrap pulse against the queues.
    always @(negedge Clk) begin
        exp_t           e;
        int             w;
        logic [WAYS-1:0] oh;
        if (Valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL show_unexpected edge=%0d: got sel=%0d y=%0d, required no SHOW",
                         cyc - base0, Sel, Y);
            end else begin
                e = exp_q.pop_front();
                oh = '0;
                oh[e.sel] = 1'b1;
                if (cyc != e.cyc || Sel !== SELW'(e.sel) || Y !== WIDTH'(e.y) || SelOneHot !== oh) begin
                    errors++;
                    $display("FAIL show_word got edge=%0d sel=%0d y=%0d oh=%h, required edge=%0d sel=%0d y=%0d oh=%h",
                             cyc - base0, Sel, Y, SelOneHot, e.cyc - base0, e.sel, e.y, oh);
                end
            end
        end else begin
            checks++;
            if (Valid !== 1'b0 || Y !== '0 || SelOneHot !== '0) begin
                errors++;
                $display("FAIL off_zero edge=%0d got valid=%b y=%0d oh=%h, required 0 0 0",
                         cyc - base0, Valid, Y, SelOneHot);
            end
        end
        if (Wrap !== 1'b0) begin
            checks++;
            if (wrap_q.size() == 0) begin
                errors++;
                $display("FAIL wrap_unexpected edge=%0d got wrap=%b sel=%0d, required no wrap",
                         cyc - base0, Wrap, Sel);
            end else begin
                w = wrap_q.pop_front();
                if (cyc != w || Sel !== '0 || Valid !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_pulse got edge=%0d sel=%0d valid=%b, required edge=%0d sel=0 valid=0",
                             cyc - base0, Sel, Valid, w - base0);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic at_edge(input int e);
        while (cyc < base0 + e) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic push_show(input int ch, input int first, input int n, input int yv);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc = base0 + first + i;
            e.sel = ch;
            e.y   = yv;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_frame(input int first);
        for (int k = 0; k < WAYS; k++) begin
            push_show(k, first + SLOT * k, DWELL, k % 8);
        end
    endtask

    task automatic set_ch(input int k, input int v);
        D[k*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(Valid), 0);
        check({tag, "_y"},     int'(Y), 0);
        check({tag, "_sel"},   int'(Sel), 0);
        check({tag, "_oh"},    int'(SelOneHot), 0);
        check({tag, "_wrap"},  int'(Wrap), 0);
    endtask

    initial begin
        Rst_n    = 1'b1;
        En       = 1'b0;
        Hold     = 1'b0;
        ForceEn  = 1'b0;
        ForceSel = '0;
        D        = '0;
        for (int k = 0; k < WAYS; k++) set_ch(k, k % 8);

        #1 Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        check_all_zero("reset");

        // Release with En high; edge 1 enters BLANK, first SHOW on edge 2.
        #5;
        base0 = cyc;
        Rst_n = 1'b1;
        En    = 1'b1;
        push_frame(2);
        wrap_q.push_back(base0 + 46);
        push_frame(47);
        wrap_q.push_back(base0 + 91);

        // Third frame: Hold on channel 3 for 10 cycles while D[3] changes.
        at_edge(91);
        push_show(0, 92, 4, 0);
        push_show(1, 97, 4, 1);
        push_show(2, 102, 4, 2);
        push_show(3, 107, 5, 3);
        push_show(3, 112, 3, 5);
        push_show(3, 115, 3, 2);
        for (int k = 4; k < WAYS; k++) push_show(k, 119 + SLOT * (k - 4), 4, k % 8);
        wrap_q.push_back(base0 + 143);
        push_show(0, 144, 4, 0);
        push_show(1, 149, 4, 1);
        push_show(2, 154, 4, 2);

        at_edge(107);
        Hold = 1'b1;
        at_edge(111);
        set_ch(3, 5);
        at_edge(114);
        set_ch(3, 2);
        at_edge(117);
        Hold = 1'b0;
        set_ch(3, 3);

        // Forced jump 2 -> 7 at dwell end, no wrap on the jump.
        at_edge(155);
        ForceEn  = 1'b1;
        ForceSel = 4'd7;
        push_show(7, 159, 4, 7);
        push_show(8, 164, 4, 0);
        wrap_q.push_back(base0 + 168);
        push_show(0, 169, 4, 0);
        push_show(1, 174, 4, 1);
        push_show(2, 179, 4, 2);
        at_edge(158);
        ForceEn = 1'b0;

        // Out-of-range force target: channel 2 is shown again.
        at_edge(180);
        ForceEn  = 1'b1;
        ForceSel = 4'd12;
        push_show(2, 184, 4, 2);
        at_edge(183);
        ForceEn = 1'b0;

        // Hold and force together: hold wins for two cycles, then force to 7.
        at_edge(185);
        Hold     = 1'b1;
        ForceEn  = 1'b1;
        ForceSel = 4'd7;
        push_show(2, 188, 2, 2);
        push_show(7, 191, 2, 7);
        at_edge(189);
        Hold = 1'b0;
        at_edge(190);
        ForceEn = 1'b0;

        // En dropped mid-SHOW: IDLE with everything cleared on the next edge.
        at_edge(192);
        En = 1'b0;
        at_edge(193);
        check_all_zero("abort");

        // Restart, then an asynchronous reset pulse in the middle of BLANK.
        at_edge(195);
        En = 1'b1;
        push_show(0, 197, 4, 0);
        at_edge(201);
        check("pre_rst_sel", int'(Sel), 1);
        check("pre_rst_valid", int'(Valid), 0);
        #2;
        Rst_n = 1'b0;
        En    = 1'b0;
        #1;
        check_all_zero("rst_async");
        at_edge(203);
        Rst_n = 1'b1;

        // Stays idle after reset until En is seen.
        at_edge(206);
        check("idle_valid", int'(Valid), 0);
        check("idle_sel", int'(Sel), 0);
        En = 1'b1;
        push_show(0, 208, 2, 0);
        at_edge(209);
        En = 1'b0;

        at_edge(214);
        check("show_left", exp_q.size(), 0);
        check("wrap_left", wrap_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
